// File: rtl/lc2k_pkg.sv
// rtl/lc2k_pkg.sv - LC2K opcode, ALU op, control state and mux-select encodings
package lc2k_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_NOR  = 3'd1,
    OP_LW   = 3'd2,
    OP_SW   = 3'd3,
    OP_BEQ  = 3'd4,
    OP_JALR = 3'd5,
    OP_HALT = 3'd6,
    OP_NOOP = 3'd7
  } opcode_e;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_NOR = 2'b01;
  localparam logic [1:0] ALU_EQ  = 2'b10;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM_RD,
    ST_MEM_WR,
    ST_WB,
    ST_JALR,
    ST_HALTED
  } state_e;

  localparam logic [1:0] PC_SRC_INC  = 2'b00;
  localparam logic [1:0] PC_SRC_ALU  = 2'b01;
  localparam logic [1:0] PC_SRC_REGA = 2'b10;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC  = 2'b10;

endpackage

// File: rtl/lc2k_control_fsm_if.sv
// rtl/lc2k_control_fsm_if.sv - memory request/ready handshake between control unit and memory
interface lc2k_control_fsm_if;

  logic memReq;
  logic memWe;
  logic memAddrSel;
  logic memReady;

  modport master (output memReq, output memWe, output memAddrSel, input memReady);
  modport slave  (input memReq, input memWe, input memAddrSel, output memReady);

endinterface

// File: rtl/lc2k_perf_counters.sv
// rtl/lc2k_perf_counters.sv - cycle and retired-instruction counters (present only with LC2K_PERF_CNT_EN)
`ifdef LC2K_PERF_CNT_EN
module lc2k_perf_counters (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        count_en,
  input  logic        retire,
  output logic [31:0] cycleCount,
  output logic [31:0] instrCount
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycleCount <= 32'd0;
      instrCount <= 32'd0;
    end else begin
      if (count_en) cycleCount <= cycleCount + 32'd1;
      if (retire)   instrCount <= instrCount + 32'd1;
    end
  end

endmodule
`endif

// File: rtl/lc2k_control_fsm.sv
// rtl/lc2k_control_fsm.sv - LC2K multicycle control FSM; LC2K_PERF_CNT_EN adds cycle/instruction counters
module lc2k_control_fsm
  import lc2k_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [2:0]                opcode,
  input  logic [2:0]                regAField,
  input  logic [2:0]                regBField,
  input  logic                      CONTROL_BEQ,
  output logic [1:0]                CONTROL_OPERATION,
  lc2k_control_fsm_if.master        mem,
  output logic                      aluSrcASel,
  output logic                      aluSrcBSel,
  output logic                      irWrite,
  output logic                      pcWrite,
  output logic [1:0]                pcSrcSel,
  output logic                      regWrite,
  output logic                      regDstSel,
  output logic [1:0]                wbSel,
  output logic                      halted,
  output logic                      instrRetired
`ifdef LC2K_PERF_CNT_EN
  ,
  output logic [31:0]               cycleCount,
  output logic [31:0]               instrCount
`endif
);

  state_e  state;
  state_e  state_next;
  opcode_e op;

  assign op = opcode_e'(opcode);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_FETCH;
    else        state <= state_next;
  end

  // Outputs are forced low while rst_n is asserted so an in-flight request drops immediately.
  always_comb begin
    state_next        = state;
    CONTROL_OPERATION = ALU_ADD;
    aluSrcASel        = 1'b0;
    aluSrcBSel        = 1'b0;
    mem.memReq        = 1'b0;
    mem.memWe         = 1'b0;
    mem.memAddrSel    = 1'b0;
    irWrite           = 1'b0;
    pcWrite           = 1'b0;
    pcSrcSel          = PC_SRC_INC;
    regWrite          = 1'b0;
    regDstSel         = 1'b0;
    wbSel             = WB_ALU;
    halted            = 1'b0;
    instrRetired      = 1'b0;
    if (rst_n) begin
      case (state)
        ST_FETCH: begin
          mem.memReq = 1'b1;
          if (mem.memReady) begin
            irWrite    = 1'b1;
            pcWrite    = 1'b1;
            state_next = ST_DECODE;
          end
        end
        ST_DECODE: begin
          // ALUOut captures PC+1+offset here so beq can use it as its target.
          aluSrcASel = 1'b1;
          aluSrcBSel = 1'b1;
          case (op)
            OP_ADD, OP_NOR, OP_LW, OP_SW, OP_BEQ: state_next = ST_EXEC;
            OP_JALR: state_next = ST_JALR;
            OP_HALT: begin
              instrRetired = 1'b1;
              state_next   = ST_HALTED;
            end
            default: begin
              instrRetired = 1'b1;
              state_next   = ST_FETCH;
            end
          endcase
        end
        ST_EXEC: begin
          case (op)
            OP_ADD: state_next = ST_WB;
            OP_NOR: begin
              CONTROL_OPERATION = ALU_NOR;
              state_next        = ST_WB;
            end
            OP_LW: begin
              aluSrcBSel = 1'b1;
              state_next = ST_MEM_RD;
            end
            OP_SW: begin
              aluSrcBSel = 1'b1;
              state_next = ST_MEM_WR;
            end
            OP_BEQ: begin
              CONTROL_OPERATION = ALU_EQ;
              if (CONTROL_BEQ) begin
                pcWrite  = 1'b1;
                pcSrcSel = PC_SRC_ALU;
              end
              instrRetired = 1'b1;
              state_next   = ST_FETCH;
            end
            default: state_next = ST_FETCH;
          endcase
        end
        ST_MEM_RD: begin
          mem.memReq     = 1'b1;
          mem.memAddrSel = 1'b1;
          if (mem.memReady) state_next = ST_WB;
        end
        ST_MEM_WR: begin
          mem.memReq     = 1'b1;
          mem.memWe      = 1'b1;
          mem.memAddrSel = 1'b1;
          if (mem.memReady) begin
            instrRetired = 1'b1;
            state_next   = ST_FETCH;
          end
        end
        ST_WB: begin
          regWrite = 1'b1;
          if (op == OP_LW) begin
            wbSel     = WB_MEM;
            regDstSel = 1'b1;
          end
          instrRetired = 1'b1;
          state_next   = ST_FETCH;
        end
        ST_JALR: begin
          // Equal registers: the link is written but PC keeps PC+1 from fetch.
          regWrite  = 1'b1;
          regDstSel = 1'b1;
          wbSel     = WB_PC;
          if (regAField != regBField) begin
            pcWrite  = 1'b1;
            pcSrcSel = PC_SRC_REGA;
          end
          instrRetired = 1'b1;
          state_next   = ST_FETCH;
        end
        ST_HALTED: halted = 1'b1;
        default:   state_next = ST_FETCH;
      endcase
    end
  end

`ifdef LC2K_PERF_CNT_EN
  lc2k_perf_counters u_perf (
    .clk        (clk),
    .rst_n      (rst_n),
    .count_en   (!halted),
    .retire     (instrRetired),
    .cycleCount (cycleCount),
    .instrCount (instrCount)
  );
`endif

endmodule
